os_array_ctrl: RTL and testbench

OS_ARRAY_CTRL -- requirements
Module: os_array_ctrl

---
 rtl/os_array_ctrl.sv | 145 ++++++++++++++
 tb/tb_os_array_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/os_array_ctrl.sv
// rtl/os_array_ctrl.sv - sequencing controller for an output-stationary PE array
// Runs skewed operand injection, pipeline flush, then a row-by-row drain of the scratch registers.
module os_array_ctrl #(
    parameter int OUT_ARRAY_DIM = 4,
    parameter int OUT_K_WIDTH   = 8,
    localparam int ROW_W        = (OUT_ARRAY_DIM > 1) ? $clog2(OUT_ARRAY_DIM) : 1
) (
    input  logic                     w_clock,
    input  logic                     w_reset,
    input  logic                     w_start,
    input  logic [OUT_K_WIDTH-1:0]   w_k_len,
    output logic                     w_busy,
    output logic                     w_done,
    output logic                     w_err,
    output logic                     w_pe_ready,
    output logic [OUT_ARRAY_DIM-1:0] w_pe_rw,
    output logic                     w_pe_stream,
    output logic [OUT_ARRAY_DIM-1:0] w_row_en,
    output logic [OUT_ARRAY_DIM-1:0] w_col_en,
    output logic                     w_drain_valid,
    input  logic                     w_drain_ready,
    output logic [ROW_W-1:0]         w_drain_row
);

    // Holds K + 2N - 3 for the largest K without wrapping.
    localparam int CNT_W = OUT_K_WIDTH + $clog2(2 * OUT_ARRAY_DIM) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPUTE,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [OUT_K_WIDTH-1:0] r_k;
    logic [CNT_W-1:0]       r_cnt;
    logic [ROW_W-1:0]       r_drain_row;
    logic                   r_err;

    logic                   w_start_ok;
    logic                   w_start_rej;
    logic                   w_cnt_last;
    logic                   w_flush_last;
    logic                   w_beat;
    logic                   w_row_last;

    assign w_start_ok   = (r_state == S_IDLE) && w_start && (w_k_len != '0);
    assign w_start_rej  = (r_state == S_IDLE) && w_start && (w_k_len == '0);
    assign w_cnt_last   = r_cnt == (CNT_W'(r_k) + CNT_W'(2 * OUT_ARRAY_DIM - 3));
    assign w_flush_last = r_cnt == CNT_W'(1);
    assign w_beat       = (r_state == S_DRAIN) && w_drain_ready;
    assign w_row_last   = r_drain_row == ROW_W'(OUT_ARRAY_DIM - 1);

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            r_k         <= '0;
            r_cnt       <= '0;
            r_drain_row <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_start_rej;
            if (w_start_ok) begin
                r_k <= w_k_len;
            end
            // The counter is shared by COMPUTE and FLUSH and restarts on every state change.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_COMPUTE || r_state == S_FLUSH) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_IDLE) begin
                r_drain_row <= '0;
            end else if (w_beat) begin
                r_drain_row <= w_row_last ? '0 : r_drain_row + ROW_W'(1);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_busy        = 1'b1;
        w_done        = 1'b0;
        w_pe_ready    = 1'b1;
        w_pe_rw       = '1;
        w_pe_stream   = 1'b0;
        w_row_en      = '0;
        w_col_en      = '0;
        w_drain_valid = 1'b0;
        w_drain_row   = r_drain_row;
        w_err         = r_err;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_pe_ready = 1'b0;
                if (w_start_ok) begin
                    w_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // Row i and column i see operands during c in [i, i+K-1].
                for (int i = 0; i < OUT_ARRAY_DIM; i++) begin
                    w_row_en[i] = (r_cnt >= CNT_W'(i)) && ((r_cnt - CNT_W'(i)) < CNT_W'(r_k));
                    w_col_en[i] = w_row_en[i];
                end
                if (w_cnt_last) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_drain_valid = 1'b1;
                for (int i = 0; i < OUT_ARRAY_DIM; i++) begin
                    w_pe_rw[i] = r_drain_row != ROW_W'(i);
                end
                if (w_beat && w_row_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done     = 1'b1;
                w_pe_ready = 1'b0;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_os_array_ctrl.sv
// tb/tb_os_array_ctrl.sv - self-checking bench for os_array_ctrl
module tb_os_array_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;

    logic          w_clock = 1'b0;
    logic          w_reset = 1'b1;
    logic          w_start = 1'b0;
    logic [KW-1:0] w_k_len = '0;
    logic          w_drain_ready = 1'b1;
    logic          w_busy, w_done, w_err, w_pe_ready, w_pe_stream, w_drain_valid;
    logic [N-1:0]  w_pe_rw, w_row_en, w_col_en;
    logic [1:0]    w_drain_row;
    logic [19:0]   w_obs;

    os_array_ctrl #(.OUT_ARRAY_DIM(N), .OUT_K_WIDTH(KW)) u_dut (
        .w_clock      (w_clock),
        .w_reset      (w_reset),
        .w_start      (w_start),
        .w_k_len      (w_k_len),
        .w_busy       (w_busy),
        .w_done       (w_done),
        .w_err        (w_err),
        .w_pe_ready   (w_pe_ready),
        .w_pe_rw      (w_pe_rw),
        .w_pe_stream  (w_pe_stream),
        .w_row_en     (w_row_en),
        .w_col_en     (w_col_en),
        .w_drain_valid(w_drain_valid),
        .w_drain_ready(w_drain_ready),
        .w_drain_row  (w_drain_row)
    );

    always #5 w_clock = ~w_clock;

    assign w_obs = {w_busy, w_done, w_pe_ready, w_pe_stream, w_err, w_pe_rw,
                    w_row_en, w_col_en, w_drain_valid, w_drain_row};

    localparam logic [19:0] IDLE_V = {5'b00000, 4'hF, 11'd0};
    localparam logic [19:0] ERR_V  = {5'b00001, 4'hF, 11'd0};

    typedef struct {
        int k;
        int sr;
        int sn;
        bit spur;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sb[$];

    always @(posedge w_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Expected outputs t cycles after the start request, with the drain stalled sn cycles on row sr.
    function automatic logic [19:0] exp_vec(input int t, input int k, input int sr, input int sn);
        int cl, d0, td, c, u, r;
        logic b, d, pr, dv;
        logic [3:0] rw, en;
        logic [1:0] row;
        cl = k + 2 * N - 2;
        d0 = cl + 3;
        td = d0 + N + sn;
        b = 0; d = 0; pr = 0; dv = 0; rw = 4'hF; en = 4'h0; row = 2'd0;
        if (t >= 1 && t <= cl) begin
            b = 1; pr = 1; c = t - 1;
            for (int i = 0; i < N; i++) en[i] = (c >= i) && (c <= i + k - 1);
        end else if (t > cl && t <= cl + 2) begin
            b = 1; pr = 1;
        end else if (t >= d0 && t < td) begin
            b = 1; pr = 1; dv = 1;
            u = t - d0;
            r = (u < sr) ? u : ((u <= sr + sn) ? sr : u - sn);
            row = r[1:0];
            rw[r] = 1'b0;
        end else if (t == td) begin
            b = 1; d = 1;
        end
        return {b, d, pr, 1'b0, 1'b0, rw, en, en, dv, row};
    endfunction

    // Caller is positioned just after a rising edge with the DUT in IDLE.
    task automatic run_job(input vec_t v, input string tag);
        int cl, d0, td;
        cl = v.k + 2 * N - 2;
        d0 = cl + 3;
        td = d0 + N + v.sn;
        sb.push_back(cyc + td);
        for (int t = 0; t <= td + 1; t++) begin
            w_start       = (t == 0) || (v.spur && (t == 2 || t == d0 + 1));
            w_k_len       = (t == 0) ? KW'(v.k) : ((t == 2) ? 8'd5 : 8'd0);
            w_drain_ready = !(v.sn > 0 && t >= d0 + v.sr && t < d0 + v.sr + v.sn);
            @(negedge w_clock);
            check($sformatf("%s_t%0d", tag, t), w_obs, exp_vec(t, v.k, v.sr, v.sn));
            @(posedge w_clock); #1;
        end
        w_start       = 1'b0;
        w_drain_ready = 1'b1;
    endtask

    always @(negedge w_clock) begin
        if (w_done === 1'b1) begin
            int exp_cyc;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: done seen at cycle %0d, required no done", cyc);
            end else begin
                exp_cyc = sb.pop_front();
                if (exp_cyc != cyc) begin
                    n_fail++;
                    $display("FAIL done_cycle: got cycle %0d required cycle %0d", cyc, exp_cyc);
                end
            end
        end
    end

    initial begin
        vec_t vecs[5];
        vec_t base;
        vecs[0] = '{k: 3,   sr: 0, sn: 0, spur: 1'b0};
        vecs[1] = '{k: 3,   sr: 1, sn: 3, spur: 1'b0};
        vecs[2] = '{k: 1,   sr: 0, sn: 0, spur: 1'b1};
        vecs[3] = '{k: 7,   sr: 3, sn: 2, spur: 1'b1};
        vecs[4] = '{k: 255, sr: 2, sn: 1, spur: 1'b0};
        base    = vecs[0];

        @(negedge w_clock);
        check("reset_hold", w_obs, IDLE_V);
        @(posedge w_clock); #1;
        w_reset = 1'b0;

        w_start = 1'b1;
        w_k_len = 8'd0;
        @(negedge w_clock);
        check("kzero_c0", w_obs, IDLE_V);
        @(posedge w_clock); #1;
        w_start = 1'b0;
        @(negedge w_clock);
        check("kzero_c1_err", w_obs, ERR_V);
        @(posedge w_clock); #1;
        @(negedge w_clock);
        check("kzero_c2", w_obs, IDLE_V);
        @(posedge w_clock); #1;

        for (int i = 0; i < 5; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        w_start = 1'b1;
        w_k_len = 8'd3;
        sb.push_back(cyc + 16);
        @(posedge w_clock); #1;
        w_start = 1'b0;
        repeat (4) @(posedge w_clock);
        #1;
        @(negedge w_clock);
        check("abort_c4", w_obs, exp_vec(5, 3, 0, 0));
        #2;
        w_reset = 1'b1;
        void'(sb.pop_back());
        #1;
        check("abort_async", w_obs, IDLE_V);
        @(posedge w_clock); #1;
        w_reset = 1'b0;
        @(negedge w_clock);
        check("abort_idle", w_obs, IDLE_V);
        @(posedge w_clock); #1;
        run_job(base, "rerun");

        repeat (20) @(posedge w_clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL done_missing: got %0d outstanding jobs required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
